// File: rtl/demux_pkg.sv
// Shared defaults for the registered 1-to-N handshake demultiplexer.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_N_OUT = 16;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output buffer for a single demux channel.
// Latency: 1 cycle from wr_en to valid/data.
// Backpressure: holds valid/data while ready=0; free also reports a slot draining this cycle.
//
// Ports: clk/rst (sync, active-high), wr_en/wr_data (fill from demux decode),
//        valid/ready/data (consumer handshake), free (slot can be written this cycle).
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // A slot being consumed this cycle can take a new beat on the same edge,
    // which is what gives one beat per cycle per channel.
    assign free = ~valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (ready) begin
            // Data is deliberately left in place once drained.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1xn_hs.sv
// Registered 1-to-N demultiplexer (unicast or broadcast) with valid/ready on every side.
// Latency: 1 cycle from input acceptance to out_valid/out_data of the target channel(s).
// Backpressure: in_ready follows only the target slot (all slots for broadcast); out-of-range beats are always accepted and dropped.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data/in_sel/in_bcast (source);
//        out_valid/out_ready/out_data (per channel, channel i at out_data[i*WIDTH +: WIDTH]);
//        err_sel (one-cycle pulse when an out-of-range unicast beat was dropped).
module demux_1xn_hs
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEMUX_WIDTH,
    parameter  int N_OUT = DEMUX_N_OUT,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   err_sel
);

    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] wr_en;
    logic             sel_ok;
    logic             accept;

    // Widened compare so non-power-of-two channel counts are range-checked
    // without a constant-result comparison for power-of-two counts.
    assign sel_ok = (32'(in_sel) < 32'(N_OUT));

    // No dependency on in_valid: the source can look at in_ready before committing.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (in_bcast) begin
                in_ready = &slot_free;
            end else if (sel_ok) begin
                in_ready = slot_free[in_sel];
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;

    // Broadcast only reaches here when every slot is free, so it is all-or-nothing.
    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        assign wr_en[i] = accept & (in_bcast | (in_sel == SEL_W'(i)));

        demux_out_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[i]),
            .wr_data (in_data),
            .valid   (out_valid[i]),
            .ready   (out_ready[i]),
            .data    (out_data[i*WIDTH +: WIDTH]),
            .free    (slot_free[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel <= 1'b0;
        end else begin
            err_sel <= accept & ~in_bcast & ~sel_ok;
        end
    end

endmodule
